// File: rtl/tl_mig_controller.sv
// TileLink slave port to DDR MIG native (app_*) bridge; one transaction in flight.
// Reads are buffered so D back-pressure never stalls the unthrottled MIG read return.
module tl_mig_controller #(
    parameter int TL_AW     = 28,
    parameter int TL_SRC    = 5,
    parameter int MAX_BEATS = 4
) (
    input  logic              interconnect_clock_i,
    input  logic              interconnect_reset_i,
    input  logic [2:0]        slave_a_opcode,
    input  logic [2:0]        slave_a_param,
    input  logic [3:0]        slave_a_size,
    input  logic [TL_SRC-1:0] slave_a_source,
    input  logic [TL_AW-1:0]  slave_a_address,
    input  logic [15:0]       slave_a_mask,
    input  logic [127:0]      slave_a_data,
    input  logic              slave_a_corrupt,
    input  logic              slave_a_valid,
    output logic              slave_a_ready,
    output logic [2:0]        slave_d_opcode,
    output logic [1:0]        slave_d_param,
    output logic [3:0]        slave_d_size,
    output logic [TL_SRC-1:0] slave_d_source,
    output logic              slave_d_denied,
    output logic [127:0]      slave_d_data,
    output logic              slave_d_corrupt,
    output logic              slave_d_valid,
    input  logic              slave_d_ready,
    output logic [27:0]       app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [127:0]      app_wdf_data,
    output logic              app_wdf_end,
    output logic [15:0]       app_wdf_mask,
    output logic              app_wdf_wren,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_end,
    input  logic              app_rd_data_valid,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy
);
    localparam int BW = TL_AW - 4;
    localparam int PW = $clog2(MAX_BEATS) + 1;
    localparam int IW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [3:0] MAX_SIZE = 4'(4 + $clog2(MAX_BEATS));
    localparam logic [2:0] OP_PUT_FULL = 3'd0, OP_PUT_PART = 3'd1, OP_ARITH = 3'd2,
                           OP_LOGIC = 3'd3, OP_GET = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_WRESP, S_DRAIN, S_ERESP} state_t;
    state_t state_q, state_d;

    logic              armed_q;
    logic [2:0]        op_q;
    logic [3:0]        size_q;
    logic [TL_SRC-1:0] src_q;
    logic [BW-1:0]     base_q;
    logic [11:0]       beat_q;
    logic              cmd_done_q, data_done_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [127:0]      rbuf [MAX_BEATS];

    logic          unused;
    logic [11:0]   nbeats, drain_n;
    logic          is_put, err_data, a_legal;
    logic [BW-1:0] beat_base;
    logic [27:0]   mig_addr;
    logic          a_hs, d_hs, cmd_hs, wdf_hs;

    assign unused    = ^{slave_a_param, slave_a_corrupt, app_rd_data_end};
    // Oversize requests can reach size 15, so the beat count needs 12 bits.
    assign nbeats    = (size_q <= 4'd4) ? 12'd1 : (12'd1 << (size_q - 4'd4));
    assign is_put    = (op_q == OP_PUT_FULL) || (op_q == OP_PUT_PART);
    assign err_data  = (op_q == OP_GET) || (op_q == OP_ARITH) || (op_q == OP_LOGIC);
    assign drain_n   = is_put ? nbeats : 12'd1;
    assign a_legal   = slave_a_size <= MAX_SIZE;
    assign beat_base = base_q + BW'(beat_q);
    // x16 DRAM: 16-byte beat = 8 column units.
    assign mig_addr  = 28'({beat_base, 3'b000});

    assign a_hs   = slave_a_valid & slave_a_ready;
    assign d_hs   = slave_d_valid & slave_d_ready;
    assign cmd_hs = app_en & app_rdy;
    assign wdf_hs = app_wdf_wren & app_wdf_rdy;

    always_comb begin
        state_d         = state_q;
        slave_a_ready   = 1'b0;
        slave_d_opcode  = 3'd0;
        slave_d_param   = 2'd0;
        slave_d_size    = 4'd0;
        slave_d_source  = '0;
        slave_d_denied  = 1'b0;
        slave_d_data    = '0;
        slave_d_corrupt = 1'b0;
        slave_d_valid   = 1'b0;
        app_addr        = '0;
        app_cmd         = 3'd0;
        app_en          = 1'b0;
        app_wdf_data    = '0;
        app_wdf_end     = 1'b0;
        app_wdf_mask    = '0;
        app_wdf_wren    = 1'b0;
        case (state_q)
            S_IDLE: if (armed_q && slave_a_valid) begin
                if (slave_a_opcode == OP_GET && a_legal) begin
                    slave_a_ready = 1'b1;
                    state_d       = S_RD;
                end else if ((slave_a_opcode == OP_PUT_FULL || slave_a_opcode == OP_PUT_PART)
                             && a_legal) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_RD: begin
                app_cmd        = 3'b001;
                app_en         = beat_q < nbeats;
                app_addr       = mig_addr;
                slave_d_valid  = rd_ptr_q < wr_ptr_q;
                slave_d_opcode = 3'd1;
                slave_d_size   = size_q;
                slave_d_source = src_q;
                slave_d_data   = rbuf[rd_ptr_q[IW-1:0]];
                if (slave_d_valid && slave_d_ready && (12'(rd_ptr_q) + 12'd1 == nbeats))
                    state_d = S_IDLE;
            end
            S_WR: begin
                app_cmd       = 3'b000;
                app_addr      = mig_addr;
                app_en        = slave_a_valid & ~cmd_done_q;
                app_wdf_wren  = slave_a_valid & ~data_done_q;
                app_wdf_end   = app_wdf_wren;
                app_wdf_data  = slave_a_data;
                app_wdf_mask  = ~slave_a_mask;
                // Beat completes once both command and data have been taken, in any order.
                slave_a_ready = slave_a_valid & (cmd_done_q | (app_en & app_rdy))
                                & (data_done_q | (app_wdf_wren & app_wdf_rdy));
                if (slave_a_ready && beat_q == nbeats - 12'd1)
                    state_d = S_WRESP;
            end
            S_WRESP: begin
                slave_d_valid  = 1'b1;
                slave_d_size   = size_q;
                slave_d_source = src_q;
                if (slave_d_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                slave_a_ready = 1'b1;
                if (slave_a_valid && beat_q == drain_n - 12'd1) state_d = S_ERESP;
            end
            S_ERESP: begin
                slave_d_valid   = 1'b1;
                slave_d_denied  = 1'b1;
                slave_d_opcode  = err_data ? 3'd1 : 3'd0;
                slave_d_corrupt = err_data;
                slave_d_size    = size_q;
                slave_d_source  = src_q;
                if (slave_d_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge interconnect_clock_i or negedge interconnect_reset_i) begin
        if (!interconnect_reset_i) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            op_q        <= '0;
            size_q      <= '0;
            src_q       <= '0;
            base_q      <= '0;
            beat_q      <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            case (state_q)
                S_IDLE: if (armed_q && slave_a_valid) begin
                    op_q        <= slave_a_opcode;
                    size_q      <= slave_a_size;
                    src_q       <= slave_a_source;
                    base_q      <= slave_a_address[TL_AW-1:4];
                    beat_q      <= '0;
                    cmd_done_q  <= 1'b0;
                    data_done_q <= 1'b0;
                    wr_ptr_q    <= '0;
                    rd_ptr_q    <= '0;
                end
                S_RD: begin
                    if (cmd_hs) beat_q <= beat_q + 12'd1;
                    if (app_rd_data_valid) wr_ptr_q <= wr_ptr_q + PW'(1);
                    if (d_hs) rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                S_WR: begin
                    if (a_hs) begin
                        cmd_done_q  <= 1'b0;
                        data_done_q <= 1'b0;
                        beat_q      <= beat_q + 12'd1;
                    end else begin
                        if (cmd_hs) cmd_done_q <= 1'b1;
                        if (wdf_hs) data_done_q <= 1'b1;
                    end
                end
                S_DRAIN: if (a_hs) beat_q <= beat_q + 12'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge interconnect_clock_i) begin
        if (state_q == S_RD && app_rd_data_valid)
            rbuf[wr_ptr_q[IW-1:0]] <= app_rd_data;
    end
endmodule

// File: tb/tb_tl_mig_controller.sv
// Bench for tl_mig_controller: TileLink master driver, behavioural MIG memory,
// and a line-granular reference memory that predicts every D beat.
module tb_tl_mig_controller;
    localparam int TL_AW = 28, TL_SRC = 5, MAX_BEATS = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [2:0] slave_a_opcode = '0, slave_a_param = '0;
    logic [3:0] slave_a_size = '0;
    logic [TL_SRC-1:0] slave_a_source = '0;
    logic [TL_AW-1:0] slave_a_address = '0;
    logic [15:0] slave_a_mask = '0;
    logic [127:0] slave_a_data = '0;
    logic slave_a_corrupt = 1'b0, slave_a_valid = 1'b0, slave_a_ready;
    logic [2:0] slave_d_opcode; logic [1:0] slave_d_param; logic [3:0] slave_d_size;
    logic [TL_SRC-1:0] slave_d_source; logic slave_d_denied, slave_d_corrupt, slave_d_valid;
    logic [127:0] slave_d_data; logic slave_d_ready = 1'b0;
    logic [27:0] app_addr; logic [2:0] app_cmd; logic app_en, app_wdf_end, app_wdf_wren;
    logic [127:0] app_wdf_data; logic [15:0] app_wdf_mask;
    logic [127:0] app_rd_data = '0;
    logic app_rd_data_end = 1'b0, app_rd_data_valid = 1'b0, app_rdy = 1'b0, app_wdf_rdy = 1'b0;

    tl_mig_controller #(.TL_AW(TL_AW), .TL_SRC(TL_SRC), .MAX_BEATS(MAX_BEATS)) dut (
        .interconnect_clock_i(clk), .interconnect_reset_i(rst_n),
        .slave_a_opcode(slave_a_opcode), .slave_a_param(slave_a_param), .slave_a_size(slave_a_size),
        .slave_a_source(slave_a_source), .slave_a_address(slave_a_address), .slave_a_mask(slave_a_mask),
        .slave_a_data(slave_a_data), .slave_a_corrupt(slave_a_corrupt), .slave_a_valid(slave_a_valid),
        .slave_a_ready(slave_a_ready), .slave_d_opcode(slave_d_opcode), .slave_d_param(slave_d_param),
        .slave_d_size(slave_d_size), .slave_d_source(slave_d_source), .slave_d_denied(slave_d_denied),
        .slave_d_data(slave_d_data), .slave_d_corrupt(slave_d_corrupt), .slave_d_valid(slave_d_valid),
        .slave_d_ready(slave_d_ready), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit rand_rdy = 1'b0, rand_dr = 1'b0;
    logic [30:0]  cmd_log [$];
    logic [143:0] wdat_log [$];
    logic [27:0]  rdq [$], waq [$];
    logic [143:0] wdq [$];
    logic [127:0] mig_mem [int];
    logic [127:0] ref_mem [int];
    logic [15:0]  d_hdr;
    logic [127:0] d_dat;
    logic [27:0]  m_a;
    logic [143:0] m_w;
    logic [127:0] m_t;

    // MIG model: drives at negedge, observes handshakes 3 ns later (well before posedge).
    always begin
        @(negedge clk);
        if (!rst_n) begin
            rdq.delete(); waq.delete(); wdq.delete();
            app_rd_data_valid = 1'b0;
        end else begin
            app_rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            app_wdf_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            app_rd_data_valid = 1'b0;
            if (rdq.size() > 0 && (!rand_rdy || $urandom_range(0, 3) != 0)) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = mig_mem[int'(rdq.pop_front())];
            end
        end
        #3;
        if (rst_n) begin
            if (app_en && app_rdy) begin
                cmd_log.push_back({app_cmd, app_addr});
                if (app_cmd == 3'b001) rdq.push_back(app_addr);
                else waq.push_back(app_addr);
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                wdat_log.push_back({app_wdf_mask, app_wdf_data});
                wdq.push_back({app_wdf_mask, app_wdf_data});
            end
            while (waq.size() > 0 && wdq.size() > 0) begin
                m_a = waq.pop_front();
                m_w = wdq.pop_front();
                m_t = mig_mem[int'(m_a)];
                for (int j = 0; j < 16; j++) if (!m_w[128+j]) m_t[8*j +: 8] = m_w[8*j +: 8];
                mig_mem[int'(m_a)] = m_t;
            end
        end
    end

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] merge(input logic [127:0] o, input logic [127:0] n,
                                           input logic [15:0] m);
        logic [127:0] r = o;
        for (int j = 0; j < 16; j++) if (m[j]) r[8*j +: 8] = n[8*j +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(negedge clk);
        slave_a_valid = 1'b0; slave_d_ready = 1'b0;
        #3;
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [3:0] sz, input logic [4:0] src,
                             input logic [27:0] addr, input logic [15:0] m, input logic [127:0] d);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            slave_a_valid = 1'b1; slave_a_opcode = op; slave_a_size = sz; slave_a_source = src;
            slave_a_address = addr; slave_a_mask = m; slave_a_data = d; slave_d_ready = 1'b0;
            #3;
            ok = slave_a_ready;
        end
        chk("a_accept", 144'(ok), 144'(1));
    endtask

    task automatic recv_d(input int hold);
        bit got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            slave_a_valid = 1'b0;
            slave_d_ready = (c < hold) ? 1'b0 : (rand_dr ? 1'($urandom_range(0, 1)) : 1'b1);
            #3;
            if (slave_d_valid && slave_d_ready) begin
                got = 1'b1;
                d_hdr = {slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
                         slave_d_denied, slave_d_corrupt};
                d_dat = slave_d_data;
            end
        end
        chk("d_arrive", 144'(got), 144'(1));
    endtask

    task automatic do_get(input logic [4:0] src, input logic [27:0] addr, input logic [3:0] sz,
                          input int hold);
        int nb = (sz <= 4) ? 1 : (1 << (sz - 4));
        int line = int'(addr >> 4);
        cmd_log.delete(); wdat_log.delete();
        send_beat(3'd4, sz, src, addr, 16'hFFFF, '0);
        for (int b = 0; b < nb; b++) begin
            recv_d(b == 0 ? hold : 0);
            chk("get_hdr", 144'(d_hdr), 144'({3'd1, 2'd0, sz, src, 2'b00}));
            chk("get_data", 144'(d_dat), 144'(ref_mem[line + b]));
        end
        chk("get_ncmd", 144'(cmd_log.size()), 144'(nb));
        for (int b = 0; b < nb && b < cmd_log.size(); b++)
            chk("get_cmd", 144'(cmd_log[b]), 144'({3'd1, 28'((line + b) * 8)}));
        chk("get_nowdf", 144'(wdat_log.size()), 144'(0));
    endtask

    task automatic do_put(input logic [2:0] op, input logic [4:0] src, input logic [27:0] addr,
                          input logic [3:0] sz, input logic [15:0] lm, input bit rmask);
        int nb = (sz <= 4) ? 1 : (1 << (sz - 4));
        int line = int'(addr >> 4);
        logic [127:0] dq [$];
        logic [15:0]  mq [$];
        logic [127:0] d;
        logic [15:0]  m;
        cmd_log.delete(); wdat_log.delete();
        for (int b = 0; b < nb; b++) begin
            d = rand128();
            m = rmask ? (lm & 16'($urandom())) : lm;
            dq.push_back(d); mq.push_back(m);
            send_beat(op, sz, src, addr, m, d);
            ref_mem[line + b] = merge(ref_mem[line + b], d, m);
        end
        recv_d(0);
        chk("put_hdr", 144'(d_hdr), 144'({3'd0, 2'd0, sz, src, 2'b00}));
        chk("put_ncmd", 144'(cmd_log.size()), 144'(nb));
        chk("put_nwdf", 144'(wdat_log.size()), 144'(nb));
        for (int b = 0; b < nb && b < cmd_log.size(); b++)
            chk("put_cmd", 144'(cmd_log[b]), 144'({3'd0, 28'((line + b) * 8)}));
        for (int b = 0; b < nb && b < wdat_log.size(); b++)
            chk("put_wdf", wdat_log[b], {~mq[b], dq[b]});
    endtask

    task automatic do_bad(input logic [2:0] op, input logic [4:0] src, input logic [27:0] addr,
                          input logic [3:0] sz, input int nsend, input logic [2:0] eop,
                          input bit ecor);
        cmd_log.delete(); wdat_log.delete();
        for (int b = 0; b < nsend; b++) send_beat(op, sz, src, addr, 16'hFFFF, rand128());
        recv_d(0);
        chk("err_hdr", 144'(d_hdr), 144'({eop, 2'd0, sz, src, 1'b1, ecor}));
        chk("err_nomig", 144'(cmd_log.size() + wdat_log.size()), 144'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, 144'({slave_a_ready, slave_d_opcode, slave_d_param, slave_d_size,
            slave_d_source, slave_d_denied, slave_d_corrupt, slave_d_valid, app_addr, app_cmd,
            app_en, app_wdf_end, app_wdf_mask, app_wdf_wren}), '0);
        chk({tag, "_ddata"}, 144'(slave_d_data), '0);
        chk({tag, "_wdata"}, 144'(app_wdf_data), '0);
    endtask

    initial begin
        logic [127:0] r;
        for (int i = 0; i < 128; i++) begin
            r = rand128();
            mig_mem[i * 8] = r;
            ref_mem[i] = r;
        end
        mig_mem[32'h20] = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
        ref_mem[4]      = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;

        repeat (2) @(negedge clk);
        #3 chk_reset("por");
        #1 rst_n = 1'b1;

        do_get(5'd5, 28'h40, 4'd4, 0);
        rand_rdy = 1'b1;
        do_put(3'd0, 5'd1, 28'h100, 4'd6, 16'hFFFF, 1'b0);
        rand_rdy = 1'b0;
        do_put(3'd1, 5'd2, 28'h100, 4'd2, 16'h000F, 1'b0);
        do_get(5'd9, 28'h100, 4'd6, 10);
        do_bad(3'd2, 5'd3, 28'h200, 4'd2, 1, 3'd1, 1'b1);
        do_bad(3'd0, 5'd4, 28'h400, 4'd7, 8, 3'd0, 1'b0);
        do_bad(3'd4, 5'd6, 28'h400, 4'd7, 1, 3'd1, 1'b1);
        do_bad(3'd5, 5'd7, 28'h300, 4'd3, 1, 3'd0, 1'b0);
        do_get(5'd8, 28'h100, 4'd4, 0);

        rand_rdy = 1'b1; rand_dr = 1'b1;
        for (int t = 0; t < 30; t++) begin
            int k = $urandom_range(0, 2);
            logic [3:0] sz = 4'($urandom_range(0, 6));
            int nb = (sz <= 4) ? 1 : (1 << (sz - 4));
            int line = $urandom_range(0, 124) & ~(nb - 1);
            int off = (sz >= 4) ? 0 : ($urandom_range(0, 15) & ~((1 << sz) - 1));
            logic [15:0] lm = (sz >= 4) ? 16'hFFFF : 16'(((1 << (1 << sz)) - 1) << off);
            logic [27:0] addr = 28'(line * 16 + off);
            logic [4:0] src = 5'($urandom_range(0, 31));
            if (k == 0) do_get(src, addr, sz, 0);
            else if (k == 1) do_put(3'd0, src, addr, sz, lm, 1'b0);
            else do_put(3'd1, src, addr, sz, lm, 1'b1);
        end

        rand_rdy = 1'b0; rand_dr = 1'b0;
        send_beat(3'd4, 4'd6, 5'd3, 28'h200, 16'hFFFF, '0);
        repeat (3) step();
        @(negedge clk);
        slave_a_valid = 1'b0; slave_d_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2 chk_reset("mid_rd");
        @(negedge clk);
        #3 chk_reset("mid_rd_next");
        @(negedge clk);
        #1 rst_n = 1'b1;
        do_get(5'd7, 28'h200, 4'd6, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_mig_controller.md
Name: tl_mig_controller

Overview:
- Sequences the single TileLink slave port produced by the interconnect's M-to-1 arbiter onto the DDR MIG native user interface (app_*).
- Converts Get / PutFullData / PutPartialData on channel A into MIG read/write commands, and returns AccessAckData / AccessAck on channel D.
- Handles one TileLink transaction at a time.
- Sits between the arbiter's slave side and the MIG; replaces direct app_* driving in the interconnect.

Parameters:
- TL_AW, 28, TileLink address width (≤ 29).
- TL_SRC, 5, slave-side source width (arbiter master index + master source).
- MAX_BEATS, 4, maximum beats per transaction, and read buffer depth. Legal a_size ≤ 4 + log2(MAX_BEATS).

Ports:
- interconnect_clock_i  in  1  clock (MIG ui_clk)
- interconnect_reset_i  in  1  asynchronous active-low reset
- slave_a_opcode  in  3  A opcode
- slave_a_param  in  3  ignored
- slave_a_size  in  4  log2 bytes
- slave_a_source  in  TL_SRC  A source
- slave_a_address  in  TL_AW  byte address
- slave_a_mask  in  16  byte enables
- slave_a_data  in  128  write data
- slave_a_corrupt  in  1  ignored
- slave_a_valid  in  1  A valid
- slave_a_ready  out  1  A ready
- slave_d_opcode  out  3  0 = AccessAck, 1 = AccessAckData
- slave_d_param  out  2  always 0
- slave_d_size  out  4  echoed a_size
- slave_d_source  out  TL_SRC  echoed a_source
- slave_d_denied  out  1  error response
- slave_d_data  out  128  read data
- slave_d_corrupt  out  1  equals denied on data responses
- slave_d_valid  out  1  D valid
- slave_d_ready  in  1  D ready
- app_addr  out  28  MIG address
- app_cmd  out  3  000 = write, 001 = read
- app_en  out  1  command valid
- app_wdf_data  out  128  write data
- app_wdf_end  out  1  tied to app_wdf_wren
- app_wdf_mask  out  16  active-high byte mask (1 = do not write)
- app_wdf_wren  out  1  write-data valid
- app_rd_data  in  128  read data
- app_rd_data_end  in  1  ignored
- app_rd_data_valid  in  1  read data valid; cannot be back-pressured
- app_rdy  in  1  command accepted
- app_wdf_rdy  in  1  write data accepted

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; counters and buffer pointers cleared.
  - No draining of in-flight MIG reads: MIG shares the same reset.
- Beats: nbeats = 1 if a_size ≤ 4, else 2^(a_size-4).
- Beat address: base is a_address[TL_AW-1:4]; beat i uses base+i.
- MIG address: app_addr = zero-extend({base+i, 3'b000}), i.e. x16 DRAM with 2-byte column units. MIG must be configured ORDERING="STRICT".
- IDLE, on slave_a_valid (latch size, source, address; clear counters):
  - Get, legal size: slave_a_ready=1 this cycle → RD.
  - PutFull/PutPartial, legal size: slave_a_ready=0 → WR.
  - Other opcode or oversize: → DRAIN.
- RD:
  - Command issue: app_cmd=001, app_en=1 while cmds_issued<nbeats; a command counts on app_en&app_rdy.
  - Buffer: each app_rd_data_valid beat is written to buffer[wr_ptr], wr_ptr++.
  - D stream: slave_d_valid=1 whenever rd_ptr<wr_ptr. opcode=1, data=buffer[rd_ptr], denied=corrupt=0. rd_ptr++ on d_valid&d_ready.
  - Beats returned to D in arrival order. Capture and D consumption in the same cycle are both honoured.
  - Last D handshake → IDLE.
  - Buffer cannot overflow: cmds_issued ≤ nbeats ≤ MAX_BEATS.
- WR, per beat:
  - app_en = a_valid & ~cmd_done, with app_cmd=000.
  - app_wdf_wren = a_valid & ~data_done.
  - app_wdf_data = a_data; app_wdf_mask = ~a_mask.
  - cmd_done sets on app_en&app_rdy; data_done sets on wren&wdf_rdy.
  - slave_a_ready = a_valid & (cmd_done | app_en&app_rdy) & (data_done | wren&wdf_rdy).
  - On the A handshake: clear both flags, beat++.
  - Last beat → WRESP.
- WRESP: slave_d_valid=1, opcode=0, denied=0, held until d_ready → IDLE.
- DRAIN:
  - slave_a_ready=1; consume nbeats for Put-type, 1 beat otherwise (oversize Put uses 2^(a_size-4) beats).
  - Then → ERESP.
- ERESP:
  - One D beat: denied=1; opcode=1 with corrupt=1 for Get/Arithmetic/Logical, otherwise opcode=0.
  - Held until d_ready → IDLE.
- No new A accepted until the D response completes. slave_d_valid is never withdrawn before d_ready.

Test Plan:
- Reset asserted mid-RD → next cycle all outputs 0, state IDLE; after release, a new Get completes normally.
- Get size 4, addr 0x40, source 5 → one app_en with cmd 001, app_addr 0x20. Return 0xDEADBEEF... → one D beat: opcode 1, size 4, source 5, identical data.
- PutFull size 6, addr 0x100, 4 beats, app_rdy and app_wdf_rdy toggling independently → exactly 4 commands at 0x80, 0x88, 0x90, 0x98; 4 data writes with mask 0; one AccessAck.
- PutPartial size 2, mask 0x000F → app_wdf_mask 0xFFF0, then AccessAck.
- Get size 6 with d_ready low for 10 cycles while 4 rd beats arrive → all buffered; 4 D beats in order once d_ready rises; no loss.
- Opcode 2 (Arithmetic) → A drained with no app_en; D: opcode 1, denied=1, corrupt=1.
